// File: rtl/risc8_fetch_if.sv
// risc8_fetch_if: bus bundle between the fetch unit and its surroundings.
//   imem_req/imem_addr/imem_data : synchronous program-memory read port
//   instr/imm/instr_pc           : assembled bundle towards decode
//   out_valid/out_ready          : bundle handshake
//   redir_en/redir_addr          : PC redirect (branch/jump/call/return)
// modport master = fetch unit, modport slave = memory + decode side.
interface risc8_fetch_if #(
  parameter int unsigned PC_WIDTH = 16
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [7:0]          imem_data;
  logic [7:0]          instr;
  logic [15:0]         imm;
  logic [PC_WIDTH-1:0] instr_pc;
  logic                out_valid;
  logic                out_ready;
  logic                redir_en;
  logic [PC_WIDTH-1:0] redir_addr;

  modport master (
    output imem_req, imem_addr, instr, imm, instr_pc, out_valid,
    input  imem_data, out_ready, redir_en, redir_addr
  );

  modport slave (
    input  imem_req, imem_addr, instr, imm, instr_pc, out_valid,
    output imem_data, out_ready, redir_en, redir_addr
  );
endinterface

// File: rtl/risc8_fetch.sv
// risc8_fetch: instruction fetch and bundle assembly for the 8-bit RISC core.
// Streams bytes from synchronous program memory through a small skid FIFO,
// assembles opcode + 0..2 immediate bytes into one bundle and offers it to
// decode over a valid/ready handshake. Redirects flush all in-flight bytes.
// Ports:
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : risc8_fetch_if.master (memory port, bundle, redirect)
//   perf_bundles/perf_bubbles : saturating 32-bit counters, only present
//                               when FETCH_PERF_EN is defined
// Optional feature macro: FETCH_PERF_EN
module risc8_fetch #(
  parameter int unsigned         PC_WIDTH   = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VEC  = '0,
  parameter int unsigned         FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  risc8_fetch_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_bundles,
  output logic [31:0]   perf_bubbles
`endif
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  // Opcodes that carry immediates; everything else has none.
  typedef enum logic [7:0] {
    CPY0  = 8'h80, CPY1 = 8'h81, CPY2 = 8'h82, CPY3 = 8'h83,
    RJUMP = 8'h90, RBWI = 8'h91,
    JUMP  = 8'hA0, CALL = 8'hA1
  } e_instr;

  typedef enum logic [1:0] {S_OP, S_IMM1, S_IMM2, S_HOLD} state_t;

  state_t              state, state_nxt;
  logic                alive;
  logic                rd_inflight;
  logic                issue;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] pop_pc;
  logic [7:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    cnt;
  logic                stored, avail, pop, pop_stored, push;
  logic [7:0]          head;
  logic [1:0]          head_len, cur_len;
  logic                load_op, load_lo, load_hi;
  logic [7:0]          instr_q;
  logic [15:0]         imm_q;
  logic [PC_WIDTH-1:0] instr_pc_q;

  function automatic logic [1:0] imm_len(input logic [7:0] op);
    logic [1:0] len;
    case (op)
      CPY0, CPY1, CPY2, CPY3, RJUMP, RBWI: len = 2'd1;
      JUMP, CALL:                          len = 2'd2;
      default:                             len = 2'd0;
    endcase
    return len;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue only while stored bytes plus the outstanding read leave room,
  // so a push can never land in a full FIFO.
  assign issue = alive && !bus.redir_en &&
                 ((32'(cnt) + 32'(rd_inflight)) < FIFO_DEPTH);

  // Returning data is visible to the assembler in the same cycle when the
  // FIFO is empty; this fall-through is what allows one bundle per cycle.
  assign stored     = (cnt != '0);
  assign avail      = stored || rd_inflight;
  assign head       = stored ? fifo_mem[rd_ptr] : bus.imem_data;
  assign head_len   = imm_len(head);
  assign pop_stored = pop && stored;
  assign push       = rd_inflight && !bus.redir_en && !(pop && !stored);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_op   = 1'b0;
    load_lo   = 1'b0;
    load_hi   = 1'b0;
    case (state)
      S_OP: if (avail) begin
        pop       = 1'b1;
        load_op   = 1'b1;
        state_nxt = (head_len != 2'd0) ? S_IMM1 : S_HOLD;
      end
      S_IMM1: if (avail) begin
        pop       = 1'b1;
        load_lo   = 1'b1;
        state_nxt = (cur_len == 2'd2) ? S_IMM2 : S_HOLD;
      end
      S_IMM2: if (avail) begin
        pop       = 1'b1;
        load_hi   = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD: if (bus.out_ready) begin
        if (avail) begin
          pop       = 1'b1;
          load_op   = 1'b1;
          state_nxt = (head_len != 2'd0) ? S_IMM1 : S_HOLD;
        end else begin
          state_nxt = S_OP;
        end
      end
      default: state_nxt = S_OP;
    endcase
    if (bus.redir_en) begin
      pop       = 1'b0;
      load_op   = 1'b0;
      load_lo   = 1'b0;
      load_hi   = 1'b0;
      state_nxt = S_OP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_OP;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      imm_q      <= '0;
      instr_pc_q <= RESET_VEC;
      cur_len    <= '0;
    end else begin
      if (load_op) begin
        instr_q    <= head;
        imm_q      <= '0;
        instr_pc_q <= pop_pc;
        cur_len    <= head_len;
      end
      if (load_lo) imm_q[7:0]  <= head;
      if (load_hi) imm_q[15:8] <= head;
    end
  end

  // A redirect suppresses issue in its own cycle, so the only read still
  // outstanding returns during that cycle and is dropped by the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive       <= 1'b0;
      rd_inflight <= 1'b0;
      fetch_pc    <= RESET_VEC;
      pop_pc      <= RESET_VEC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      cnt         <= '0;
    end else begin
      alive <= 1'b1;
      if (bus.redir_en) begin
        rd_inflight <= 1'b0;
        fetch_pc    <= bus.redir_addr;
        pop_pc      <= bus.redir_addr;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        cnt         <= '0;
      end else begin
        rd_inflight <= issue;
        if (issue)      fetch_pc <= fetch_pc + PC_WIDTH'(1);
        if (pop)        pop_pc   <= pop_pc + PC_WIDTH'(1);
        if (push)       wr_ptr   <= ptr_inc(wr_ptr);
        if (pop_stored) rd_ptr   <= ptr_inc(rd_ptr);
        cnt <= cnt + CNT_W'(push) - CNT_W'(pop_stored);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.imem_data;
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;
  assign bus.instr     = instr_q;
  assign bus.imm       = imm_q;
  assign bus.instr_pc  = instr_pc_q;
  assign bus.out_valid = (state == S_HOLD);

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bundles <= '0;
      perf_bubbles <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready && (perf_bundles != '1))
        perf_bundles <= perf_bundles + 32'd1;
      if (!bus.out_valid && bus.out_ready && (perf_bubbles != '1))
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_risc8_fetch.sv
// tb_risc8_fetch: scoreboard bench for risc8_fetch. A program-memory model
// answers reads; the expected bundle stream is derived by walking memory
// from the current start address (opcode, then its immediate bytes) and is
// queued as stimulus runs; a negedge monitor pops and compares each transfer.
module tb_risc8_fetch;
  localparam logic [15:0] RESET_VEC = 16'h0000;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] imm;
    logic [15:0] pc;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  mem [65536];
  logic [7:0]  ops [8] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h90, 8'h91, 8'hA0, 8'hA1};
  bundle_t     exp_q [$];
  logic [15:0] model_pc;
  int          checks = 0;
  int          errors = 0;
  logic        hold_pending = 1'b0;
  logic [39:0] held;
  logic        found;
  int          m_bundles = 0;
  int          m_bubbles = 0;

  risc8_fetch_if #(.PC_WIDTH(16)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_bundles, perf_bubbles;
`endif

  risc8_fetch #(.PC_WIDTH(16), .RESET_VEC(RESET_VEC), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_bundles (perf_bundles),
    .perf_bubbles (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  initial bus.imem_data = 8'h00;
  always @(posedge clk) if (bus.imem_req) bus.imem_data <= mem[bus.imem_addr];

  function automatic int ref_len(input logic [7:0] op);
    if (op inside {8'h80, 8'h81, 8'h82, 8'h83, 8'h90, 8'h91}) return 1;
    if (op inside {8'hA0, 8'hA1}) return 2;
    return 0;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic restart(input logic [15:0] a);
    exp_q.delete();
    model_pc = a;
  endtask

  task automatic top_up();
    bundle_t b;
    int      n;
    while (exp_q.size() < 8) begin
      b.op  = mem[model_pc];
      b.pc  = model_pc;
      b.imm = 16'h0000;
      n     = ref_len(b.op);
      if (n >= 1) b.imm[7:0]  = mem[model_pc + 16'd1];
      if (n == 2) b.imm[15:8] = mem[model_pc + 16'd2];
      exp_q.push_back(b);
      model_pc = model_pc + 16'(1 + n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    top_up();
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Called at posedge+1; returns at posedge+1 after the redirect edge.
  task automatic redirect(input logic [15:0] a);
    bus.redir_en   = 1'b1;
    bus.redir_addr = a;
    @(posedge clk);
    #1;
    bus.redir_en = 1'b0;
    restart(a);
    top_up();
  endtask

  // Called at posedge+1 with rst_n low; returns at posedge+1, two edges later.
  task automatic release_reset();
    rst_n = 1'b1;
    restart(RESET_VEC);
    top_up();
    at_neg();
    check("req_before_first_edge", 64'(bus.imem_req), 64'd0);
    step();
    at_neg();
    check("req_first_cycle", 64'(bus.imem_req), 64'd1);
    check("addr_first_cycle", 64'(bus.imem_addr), 64'(RESET_VEC));
    step();
  endtask

  task automatic find_pc(input logic [15:0] pc, output logic hit);
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      at_neg();
      if (bus.out_valid && bus.instr_pc == pc) begin
        hit = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Monitor: bundle scoreboard, stall stability, perf reference counts.
  always @(negedge clk) begin
    bundle_t e;
    if (!rst_n) begin
      hold_pending = 1'b0;
      m_bundles    = 0;
      m_bubbles    = 0;
    end else begin
      if (hold_pending)
        check("hold_stable", 64'({bus.out_valid, bus.instr, bus.imm, bus.instr_pc}),
              64'({1'b1, held}));
      hold_pending = bus.out_valid && !bus.out_ready && !bus.redir_en;
      held         = {bus.instr, bus.imm, bus.instr_pc};
      if (bus.out_valid && bus.out_ready) begin
        m_bundles++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bundle_unexpected got=%0h expected=none at %0t",
                   {bus.instr, bus.imm, bus.instr_pc}, $time);
        end else begin
          e = exp_q.pop_front();
          check("bundle", 64'({bus.instr, bus.imm, bus.instr_pc}), 64'(e));
        end
      end
      if (bus.out_ready && !bus.out_valid) m_bubbles++;
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.out_ready  = 1'b0;
    bus.redir_en   = 1'b0;
    bus.redir_addr = 16'h0000;
    for (int i = 0; i < 65536; i++)
      mem[i] = ($urandom_range(0, 99) < 35) ? ops[$urandom_range(0, 7)] : 8'($urandom);
    for (int i = 0; i < 3; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'h00;
    mem[16'h0200] = 8'h81; mem[16'h0201] = 8'h5A;
    mem[16'h0202] = 8'hA0; mem[16'h0203] = 8'h34; mem[16'h0204] = 8'h12;
    mem[16'h0205] = 8'h00;
    mem[16'hFFFF] = 8'h91;

    // Reset values
    repeat (2) step();
    at_neg();
    check("rst_imem_req", 64'(bus.imem_req), 64'd0);
    check("rst_imem_addr", 64'(bus.imem_addr), 64'(RESET_VEC));
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_instr", 64'(bus.instr), 64'd0);
    check("rst_imm", 64'(bus.imm), 64'd0);
    check("rst_instr_pc", 64'(bus.instr_pc), 64'(RESET_VEC));
`ifdef FETCH_PERF_EN
    check("rst_perf_bundles", 64'(perf_bundles), 64'd0);
`endif
    step();

    // Zero-immediate stream: one bundle per cycle from the third cycle on
    bus.out_ready = 1'b1;
    release_reset();
    at_neg();
    check("stream_not_yet", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      at_neg();
      check("stream_valid", 64'(bus.out_valid), 64'd1);
      check("stream_pc", 64'(bus.instr_pc), 64'(i));
    end
    step();

    // CPY then JUMP, JUMP held under back-pressure
    redirect(16'h0200);
    find_pc(16'h0200, found);
    check("cpy_seen", 64'(found), 64'd1);
    check("cpy_imm", 64'(bus.imm), 64'h005A);
    step();
    bus.out_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      at_neg();
      if (bus.out_valid) begin found = 1'b1; break; end
      step();
    end
    check("jump_seen", 64'(found), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_imm", 64'(bus.imm), 64'h1234);
      check("stall_pc", 64'(bus.instr_pc), 64'h0202);
      if (i < 4) begin step(); at_neg(); end
    end
    step();
    bus.out_ready = 1'b1;
    repeat (4) step();

    // Redirect with a read in flight: three-cycle latency to the new bundle
    bus.redir_en   = 1'b1;
    bus.redir_addr = 16'h0100;
    @(posedge clk);
    #1;
    bus.redir_en = 1'b0;
    restart(16'h0100);
    top_up();
    at_neg();
    check("redir_lat1_valid", 64'(bus.out_valid), 64'd0);
    step();
    at_neg();
    check("redir_lat2_valid", 64'(bus.out_valid), 64'd0);
    step();
    at_neg();
    check("redir_lat3_valid", 64'(bus.out_valid), 64'd1);
    check("redir_lat3_pc", 64'(bus.instr_pc), 64'h0100);
    step();
    repeat (4) step();

    // Immediate wraps from 0xFFFF to 0x0000
    mem[16'h0000] = 8'h5A;
    redirect(16'hFFFF);
    find_pc(16'hFFFF, found);
    check("wrap_seen", 64'(found), 64'd1);
    check("wrap_bundle", 64'({bus.instr, bus.imm}), 64'h91005A);
    step();
    find_pc(16'h0001, found);
    check("wrap_next_pc", 64'(found), 64'd1);
    step();

    // Reset asserted while the assembler waits on the first immediate
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    mem[16'h0000] = 8'hA1; mem[16'h0001] = 8'h34; mem[16'h0002] = 8'h12;
    repeat (2) step();
    release_reset();
    step();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_imm1_valid", 64'(bus.out_valid), 64'd0);
    check("rst_imm1_req", 64'(bus.imem_req), 64'd0);
    check("rst_imm1_addr", 64'(bus.imem_addr), 64'(RESET_VEC));
    step();
`ifdef FETCH_PERF_EN
    check("rst_imm1_perf", 64'(perf_bundles), 64'd0);
`endif
    step();
    release_reset();
    find_pc(RESET_VEC, found);
    check("call_seen", 64'(found), 64'd1);
    check("call_bundle", 64'({bus.instr, bus.imm}), 64'hA11234);
    step();

    // Randomised traffic: back-pressure and redirects
    for (int c = 0; c < 3000; c++) begin
      step();
      bus.out_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 3) begin
        if ($urandom_range(0, 4) == 0) redirect(16'hFFF0 + 16'($urandom_range(0, 15)));
        else                           redirect(16'($urandom));
      end
    end

    step();
    bus.out_ready = 1'b0;
    step();
    at_neg();
`ifdef FETCH_PERF_EN
    check("perf_bundles", 64'(perf_bundles), 64'(m_bundles));
    check("perf_bubbles", 64'(perf_bubbles), 64'(m_bubbles));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
